// File: rtl/prescaled_counter_bank_if.sv
// Control/status bundle for prescaled_counter_bank: host drives control, block drives the timebase outputs.
interface prescaled_counter_bank_if #(
  parameter int COUNTER_WIDTH  = 22,
  parameter int PRESCALE_WIDTH = 16,
  parameter int NUM_CH         = 2,
  parameter int SEL_WIDTH      = 1
) ();
  logic                            en;
  logic [PRESCALE_WIDTH-1:0]       prescale_limit;
  logic [COUNTER_WIDTH-1:0]        top_value;
  logic [2*NUM_CH-1:0]             mode;
  logic                            load;
  logic [SEL_WIDTH-1:0]            ch_sel;
  logic [COUNTER_WIDTH-1:0]        load_value;
  logic                            tick_o;
  logic [NUM_CH*COUNTER_WIDTH-1:0] count_o;
  logic [NUM_CH-1:0]               tc_o;

  modport master (
    output en, prescale_limit, top_value, mode, load, ch_sel, load_value,
    input  tick_o, count_o, tc_o
  );

  modport slave (
    input  en, prescale_limit, top_value, mode, load, ch_sel, load_value,
    output tick_o, count_o, tc_o
  );
endinterface

// File: rtl/prescaled_counter_bank.sv
// Shared programmable prescaler feeding NUM_CH counters, each in hold/up/down/one-shot mode
// with a registered one-cycle terminal-count pulse.
module prescaled_counter_bank #(
  parameter int COUNTER_WIDTH  = 22,
  parameter int PRESCALE_WIDTH = 16,
  parameter int NUM_CH         = 2,
  parameter int SEL_WIDTH      = 1
) (
  input  logic clk,
  input  logic rst_n,
  prescaled_counter_bank_if.slave bus
);
  localparam int CW = COUNTER_WIDTH;

  localparam logic [1:0] MODE_HOLD    = 2'b00;
  localparam logic [1:0] MODE_UP      = 2'b01;
  localparam logic [1:0] MODE_DOWN    = 2'b10;
  localparam logic [1:0] MODE_ONESHOT = 2'b11;

  logic [PRESCALE_WIDTH-1:0] prescale_q;
  logic [PRESCALE_WIDTH-1:0] prescale_d;
  logic                      tick;

  // >= rather than == so lowering the limit below the running count ticks at once.
  assign tick       = bus.en && (prescale_q >= bus.prescale_limit);
  assign bus.tick_o = tick;

  always_comb begin
    prescale_d = prescale_q;
    if (tick) begin
      prescale_d = '0;
    end else if (bus.en) begin
      prescale_d = prescale_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescale_q <= '0;
    end else begin
      prescale_q <= prescale_d;
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          tc_q;
    logic          tc_d;
    logic          load_hit;
    logic [1:0]    ch_mode;

    // Out-of-range ch_sel values match no channel, so the load is dropped.
    assign load_hit = bus.load && (32'(bus.ch_sel) == gi);
    assign ch_mode  = bus.mode[2*gi +: 2];

    always_comb begin
      count_d = count_q;
      tc_d    = 1'b0;
      if (load_hit) begin
        count_d = bus.load_value;
      end else if (tick) begin
        case (ch_mode)
          MODE_HOLD: count_d = count_q;
          MODE_UP: begin
            if (count_q >= bus.top_value) begin
              count_d = '0;
              tc_d    = 1'b1;
            end else begin
              count_d = count_q + 1'b1;
            end
          end
          MODE_DOWN: begin
            if (count_q == '0) begin
              count_d = bus.top_value;
              tc_d    = 1'b1;
            end else begin
              count_d = count_q - 1'b1;
            end
          end
          MODE_ONESHOT: begin
            if (count_q == CW'(1)) begin
              count_d = '0;
              tc_d    = 1'b1;
            end else if (count_q != '0) begin
              count_d = count_q - 1'b1;
            end
          end
          default: count_d = count_q;
        endcase
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        count_q <= '0;
        tc_q    <= 1'b0;
      end else begin
        count_q <= count_d;
        tc_q    <= tc_d;
      end
    end

    assign bus.count_o[gi*CW +: CW] = count_q;
    assign bus.tc_o[gi]             = tc_q;
  end
endmodule

// File: tb/tb_prescaled_counter_bank.sv
// Directed bench for prescaled_counter_bank: stimulus queues expected per-cycle outputs,
// a negedge monitor pops and compares them.
module tb_prescaled_counter_bank;
  localparam int CW  = 22;
  localparam int PW  = 16;
  localparam int NCH = 3;
  localparam int SW  = 2;
  localparam logic [CW-1:0] ALL1 = {CW{1'b1}};

  logic clk;
  logic rst_n;

  prescaled_counter_bank_if #(
    .COUNTER_WIDTH(CW), .PRESCALE_WIDTH(PW), .NUM_CH(NCH), .SEL_WIDTH(SW)
  ) bus ();

  prescaled_counter_bank #(
    .COUNTER_WIDTH(CW), .PRESCALE_WIDTH(PW), .NUM_CH(NCH), .SEL_WIDTH(SW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string         name;
    logic          tick;
    logic [CW-1:0] c0;
    logic [CW-1:0] c1;
    logic [CW-1:0] c2;
    logic [2:0]    tc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Monitor: outputs are valid every cycle, so one expectation is consumed per negedge.
  always @(negedge clk) begin
    exp_t e;
    logic [CW-1:0] a0, a1, a2;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      a0 = bus.count_o[0*CW +: CW];
      a1 = bus.count_o[1*CW +: CW];
      a2 = bus.count_o[2*CW +: CW];
      checks++;
      if (bus.tick_o !== e.tick || a0 !== e.c0 || a1 !== e.c1 || a2 !== e.c2 || bus.tc_o !== e.tc) begin
        errors++;
        $display("FAIL %s: got tick=%0b c0=%0d c1=%0d c2=%0d tc=%b, need tick=%0b c0=%0d c1=%0d c2=%0d tc=%b",
                 e.name, bus.tick_o, a0, a1, a2, bus.tc_o, e.tick, e.c0, e.c1, e.c2, e.tc);
      end else begin
        $display("ok   %s: tick=%0b c0=%0d c1=%0d c2=%0d tc=%b", e.name, e.tick, e.c0, e.c1, e.c2, e.tc);
      end
    end
  end

  task automatic cyc(input string nm, input logic t, input logic [CW-1:0] a,
                     input logic [CW-1:0] b, input logic [CW-1:0] c, input logic [2:0] tc);
    exp_t e;
    e.name = nm;
    e.tick = t;
    e.c0   = a;
    e.c1   = b;
    e.c2   = c;
    e.tc   = tc;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int dn_c0 [7] = '{0, 3, 2, 1, 0, 3, 2};
    int dn_c1 [7] = '{2, 1, 0, 0, 0, 0, 0};
    int dn_tc [7] = '{0, 1, 2, 0, 0, 1, 0};

    rst_n              = 1'b0;
    bus.en             = 1'b0;
    bus.prescale_limit = '0;
    bus.top_value      = '0;
    bus.mode           = '0;
    bus.load           = 1'b0;
    bus.ch_sel         = '0;
    bus.load_value     = '0;
    @(posedge clk);
    #1;
    cyc("reset_idle", 1'b0, 0, 0, 0, 3'b000);

    // Limit 6: tick in every 7th cycle, ch0 counts ticks seen so far.
    bus.en             = 1'b1;
    bus.prescale_limit = 16'd6;
    bus.mode           = 6'b00_00_01;
    bus.top_value      = ALL1;
    rst_n              = 1'b1;
    for (int k = 0; k < 31; k++) begin
      cyc("prescale", (k % 7) == 6, CW'(k / 7), 0, 0, 3'b000);
    end

    // Asynchronous reset with count=4, prescale=3: cleared before any edge.
    rst_n  = 1'b0;
    bus.en = 1'b0;
    cyc("async_reset", 1'b0, 0, 0, 0, 3'b000);
    bus.en             = 1'b1;
    bus.prescale_limit = '0;
    cyc("reset_tick_lim0", 1'b1, 0, 0, 0, 3'b000);
    bus.prescale_limit = 16'd2;
    rst_n              = 1'b1;
    cyc("post_reset_p0", 1'b0, 0, 0, 0, 3'b000);
    cyc("post_reset_p1", 1'b0, 0, 0, 0, 3'b000);
    cyc("post_reset_p2", 1'b1, 0, 0, 0, 3'b000);

    // UP wrap at top=5 with a tick every cycle.
    bus.load           = 1'b1;
    bus.ch_sel         = 2'd0;
    bus.load_value     = '0;
    bus.prescale_limit = '0;
    bus.top_value      = CW'(5);
    cyc("up_load", 1'b1, 1, 0, 0, 3'b000);
    bus.load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc("up_wrap", 1'b1, CW'((i < 6) ? i : i - 6), 0, 0, (i == 6) ? 3'b001 : 3'b000);
    end

    // DOWN on ch0 and ONESHOT on ch1, top=3, set up with the prescaler frozen.
    bus.en         = 1'b0;
    bus.load       = 1'b1;
    bus.ch_sel     = 2'd0;
    bus.load_value = '0;
    bus.mode       = 6'b00_11_10;
    bus.top_value  = CW'(3);
    cyc("down_setup", 1'b0, 2, 0, 0, 3'b000);
    bus.ch_sel     = 2'd1;
    bus.load_value = CW'(2);
    cyc("oneshot_setup", 1'b0, 0, 0, 0, 3'b000);
    bus.load = 1'b0;
    bus.en   = 1'b1;
    for (int i = 0; i < 7; i++) begin
      cyc("down_oneshot", 1'b1, CW'(dn_c0[i]), CW'(dn_c1[i]), 0, 3'(dn_tc[i]));
    end

    // Load collides with a tick on ch1; ch0 still steps; out-of-range select ignored.
    bus.mode       = 6'b00_01_01;
    bus.top_value  = ALL1;
    bus.load       = 1'b1;
    bus.ch_sel     = 2'd1;
    bus.load_value = CW'(9);
    cyc("load_collide", 1'b1, 1, 0, 0, 3'b000);
    bus.ch_sel     = 2'd3;
    bus.load_value = CW'(77);
    cyc("bad_sel", 1'b1, 2, 9, 0, 3'b000);
    bus.load      = 1'b0;
    bus.top_value = CW'(5);
    cyc("over_top", 1'b1, 3, 10, 0, 3'b000);
    cyc("over_top_wrap", 1'b1, 4, 0, 0, 3'b010);
    cyc("up_top", 1'b1, 5, 1, 0, 3'b000);
    bus.load       = 1'b1;
    bus.ch_sel     = 2'd0;
    bus.load_value = ALL1;
    bus.top_value  = ALL1;
    cyc("up_wrap2", 1'b1, 0, 2, 0, 3'b001);
    bus.load = 1'b0;
    cyc("all_ones", 1'b1, ALL1, 3, 0, 3'b000);
    cyc("natural_wrap", 1'b1, 0, 4, 0, 3'b001);

    // Limit lowered from 20 to 4 while prescale=10.
    bus.prescale_limit = 16'd20;
    for (int i = 0; i < 10; i++) begin
      cyc("lim_hold", 1'b0, 1, 5, 0, 3'b000);
    end
    bus.prescale_limit = 16'd4;
    cyc("lim_lower", 1'b1, 1, 5, 0, 3'b000);
    for (int i = 0; i < 5; i++) begin
      cyc("lim_period", i == 4, 2, 6, 0, 3'b000);
    end
    cyc("freeze_pre", 1'b0, 3, 7, 0, 3'b000);
    cyc("freeze_pre", 1'b0, 3, 7, 0, 3'b000);
    bus.en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc("freeze", 1'b0, 3, 7, 0, 3'b000);
    end
    bus.en = 1'b1;
    cyc("resume_p2", 1'b0, 3, 7, 0, 3'b000);
    cyc("resume_p3", 1'b0, 3, 7, 0, 3'b000);
    cyc("resume_p4", 1'b1, 3, 7, 0, 3'b000);
    cyc("resume", 1'b0, 4, 8, 0, 3'b000);

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, need 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
